// File: rtl/logic_nbit_seq_if.sv
// -----------------------------------------------------------------------------
// logic_nbit_seq_if
// Request/result bundle for the sliced bitwise logic unit.
//   start : request strobe, sampled only while the unit is idle or completing
//   oprn  : 3-bit operation code
//   a, b  : WIDTH-bit operands
//   y     : registered WIDTH-bit result
//   busy  : high while slices are being evaluated
//   done  : one-cycle completion pulse
//   zero  : registered (y == 0) flag
// master drives the request side, slave (the logic unit) drives the result side.
// -----------------------------------------------------------------------------
interface logic_nbit_seq_if #(
  parameter int WIDTH = 32
) ();
  logic             start;
  logic [2:0]       oprn;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] y;
  logic             busy;
  logic             done;
  logic             zero;

  modport master (
    output start, oprn, a, b,
    input  y, busy, done, zero
  );

  modport slave (
    input  start, oprn, a, b,
    output y, busy, done, zero
  );
endinterface

// File: rtl/logic_nbit_seq.sv
// -----------------------------------------------------------------------------
// logic_nbit_seq
// Multi-cycle bitwise logic unit. Operands and opcode are latched on a START
// edge, then the operation is evaluated SLICE bits per clock, lowest slice
// first. The complete result is published on Y together with ZERO and a
// one-cycle DONE pulse; partial results stay in an internal accumulator.
// Ports:
//   clk_i : clock, all state updates on the rising edge
//   rst_i : synchronous active-high reset
//   bus   : logic_nbit_seq_if.slave (start/oprn/a/b in, y/busy/done/zero out)
// Parameters:
//   WIDTH : operand/result width
//   SLICE : bits evaluated per RUN cycle, must divide WIDTH
// -----------------------------------------------------------------------------
module logic_nbit_seq #(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic            clk_i,
  input  logic            rst_i,
  logic_nbit_seq_if.slave bus
);

  localparam int N     = WIDTH / SLICE;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  // Refuse to build a unit whose slices do not tile the operand exactly.
  if ((WIDTH % SLICE) != 0) begin : g_bad_slice
    $error("logic_nbit_seq: WIDTH must be a multiple of SLICE");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] acc_d;
  logic [WIDTH-1:0] y_q;
  logic             zero_q;
  logic             busy_q;
  logic             done_q;
  logic [IDX_W-1:0] off_s;

  // One slice of the selected bitwise operation; bit i depends only on bit i.
  function automatic logic [SLICE-1:0] op_f(input logic [2:0]       op,
                                            input logic [SLICE-1:0] x,
                                            input logic [SLICE-1:0] z);
    logic [SLICE-1:0] r;
    case (op)
      3'b000:  r = x & z;
      3'b001:  r = x | z;
      3'b010:  r = ~(x | z);
      3'b011:  r = ~x;
      3'b100:  r = x ^ z;
      3'b101:  r = x;
      3'b110:  r = ~(x & z);
      3'b111:  r = ~(x ^ z);
      default: r = {SLICE{1'b0}};
    endcase
    return r;
  endfunction

  // Accumulator with the current slice merged in; only committed while in RUN.
  always_comb begin
    off_s = IDX_W'(32'(cnt_q) * 32'(SLICE));
    acc_d = acc_q;
    acc_d[off_s +: SLICE] = op_f(op_q, a_q[off_s +: SLICE], b_q[off_s +: SLICE]);
  end

  // Control FSM; all outputs are registered here so Y never shows partial data.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= {CNT_W{1'b0}};
      a_q     <= {WIDTH{1'b0}};
      b_q     <= {WIDTH{1'b0}};
      op_q    <= 3'b000;
      acc_q   <= {WIDTH{1'b0}};
      y_q     <= {WIDTH{1'b0}};
      zero_q  <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            a_q     <= bus.a;
            b_q     <= bus.b;
            op_q    <= bus.oprn;
            cnt_q   <= {CNT_W{1'b0}};
            acc_q   <= {WIDTH{1'b0}};
            busy_q  <= 1'b1;
            state_q <= ST_RUN;
          end else begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        ST_RUN: begin
          acc_q <= acc_d;
          // Last slice: publish the full result including this edge's slice.
          if (cnt_q == CNT_W'(N - 1)) begin
            y_q     <= acc_d;
            zero_q  <= (acc_d == {WIDTH{1'b0}});
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            cnt_q   <= {CNT_W{1'b0}};
            state_q <= ST_DONE;
          end else begin
            cnt_q   <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          cnt_q   <= {CNT_W{1'b0}};
        end
      endcase
    end
  end

  assign bus.y    = y_q;
  assign bus.zero = zero_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule

// File: tb/tb_logic_nbit_seq.sv
// -----------------------------------------------------------------------------
// tb_logic_nbit_seq
// Directed bench for logic_nbit_seq: default 32/8 instance plus 16/16 and 64/4
// instances sharing one clock and reset. Inputs are driven and outputs sampled
// on the falling edge.
// -----------------------------------------------------------------------------
module tb_logic_nbit_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  logic_nbit_seq_if #(.WIDTH(32)) if0 ();
  logic_nbit_seq_if #(.WIDTH(16)) if16 ();
  logic_nbit_seq_if #(.WIDTH(64)) if64 ();

  logic_nbit_seq #(.WIDTH(32), .SLICE(8))  dut0  (.clk_i(clk), .rst_i(rst), .bus(if0));
  logic_nbit_seq #(.WIDTH(16), .SLICE(16)) dut16 (.clk_i(clk), .rst_i(rst), .bus(if16));
  logic_nbit_seq #(.WIDTH(64), .SLICE(4))  dut64 (.clk_i(clk), .rst_i(rst), .bus(if64));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ref64(input logic [2:0] op, input logic [63:0] a,
                                        input logic [63:0] b);
    case (op)
      3'd0:    return a & b;
      3'd1:    return a | b;
      3'd2:    return ~(a | b);
      3'd3:    return ~a;
      3'd4:    return a ^ b;
      3'd5:    return a;
      3'd6:    return ~(a & b);
      default: return ~(a ^ b);
    endcase
  endfunction

  // Issue one op on the 32-bit unit and wait (bounded) for DONE.
  task automatic run0(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                      output int edges, output int busy_n, output bit overlap,
                      output bit y_stable);
    logic [31:0] y0;
    y0 = if0.y;
    overlap = 1'b0;
    y_stable = 1'b1;
    if0.oprn = op;
    if0.a = a;
    if0.b = b;
    if0.start = 1'b1;
    edges = 0;
    busy_n = 0;
    do begin
      @(negedge clk);
      edges++;
      if0.start = 1'b0;
      if (if0.busy) busy_n++;
      if (if0.busy && if0.done) overlap = 1'b1;
      if (!if0.done && (if0.y !== y0)) y_stable = 1'b0;
    end while (!if0.done && edges < 40);
  endtask

  // Issue one op on the 64-bit unit and wait (bounded) for DONE.
  task automatic run64(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                       output int edges);
    if64.oprn = op;
    if64.a = a;
    if64.b = b;
    if64.start = 1'b1;
    edges = 0;
    do begin
      @(negedge clk);
      edges++;
      if64.start = 1'b0;
    end while (!if64.done && edges < 60);
  endtask

  initial begin
    int          e;
    int          bn;
    bit          ov;
    bit          ys;
    int          dcnt;
    int          dedge;
    logic [31:0] sweep_exp [8];
    logic [31:0] ydone;
    logic [63:0] a64;
    logic [63:0] b64;

    sweep_exp[0] = 32'h2424_2424;
    sweep_exp[1] = 32'hBDBD_BDBD;
    sweep_exp[2] = 32'h4242_4242;
    sweep_exp[3] = 32'h5A5A_5A5A;
    sweep_exp[4] = 32'h9999_9999;
    sweep_exp[5] = 32'hA5A5_A5A5;
    sweep_exp[6] = 32'hDBDB_DBDB;
    sweep_exp[7] = 32'h6666_6666;

    if0.start = 1'b0;  if0.oprn = 3'd0;  if0.a = '0;  if0.b = '0;
    if16.start = 1'b0; if16.oprn = 3'd0; if16.a = '0; if16.b = '0;
    if64.start = 1'b0; if64.oprn = 3'd0; if64.a = '0; if64.b = '0;

    // Reset state
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_y", 64'(if0.y), 64'h0);
    check("rst_zero", 64'(if0.zero), 64'h1);
    check("rst_busy", 64'(if0.busy), 64'h0);
    check("rst_done", 64'(if0.done), 64'h0);

    // Default AND
    run0(3'b000, 32'hF0F0_1234, 32'h0FF0_FFFF, e, bn, ov, ys);
    check("and_edges", 64'(e), 64'd5);
    check("and_busy_cycles", 64'(bn), 64'd4);
    check("and_overlap", 64'(ov), 64'd0);
    check("and_y", 64'(if0.y), 64'h00F0_1234);
    check("and_zero", 64'(if0.zero), 64'h0);
    @(negedge clk);
    check("and_done_one_cycle", 64'(if0.done), 64'h0);
    check("and_y_hold", 64'(if0.y), 64'h00F0_1234);

    // Opcode sweep
    for (int i = 0; i < 8; i++) begin
      run0(3'(i), 32'hA5A5_A5A5, 32'h3C3C_3C3C, e, bn, ov, ys);
      check($sformatf("sweep_edges_op%0d", i), 64'(e), 64'd5);
      check($sformatf("sweep_y_op%0d", i), 64'(if0.y), 64'(sweep_exp[i]));
      @(negedge clk);
    end

    // Operand hold and ignored START during RUN
    if0.oprn = 3'b100;
    if0.a = 32'h1234_5678;
    if0.b = 32'hFFFF_0000;
    if0.start = 1'b1;
    @(negedge clk);
    dcnt = 0;
    dedge = 0;
    ydone = '0;
    for (int k = 1; k <= 11; k++) begin
      if0.a = $urandom;
      if0.b = $urandom;
      if0.oprn = 3'($urandom_range(7, 0));
      if0.start = (k == 2);
      @(negedge clk);
      if (if0.done) begin
        dcnt++;
        if (dedge == 0) begin
          dedge = k + 1;
          ydone = if0.y;
        end
      end
    end
    if0.start = 1'b0;
    check("hold_done_count", 64'(dcnt), 64'd1);
    check("hold_done_edge", 64'(dedge), 64'd5);
    check("hold_y", 64'(ydone), 64'hEDCB_5678);
    check("hold_y_after", 64'(if0.y), 64'hEDCB_5678);

    // Back-to-back with zero flag
    run0(3'b100, 32'hDEAD_BEEF, 32'hDEAD_BEEF, e, bn, ov, ys);
    check("b2b1_edges", 64'(e), 64'd5);
    check("b2b1_y", 64'(if0.y), 64'h0);
    check("b2b1_zero", 64'(if0.zero), 64'h1);
    run0(3'b001, 32'h0, 32'h1, e, bn, ov, ys);
    check("b2b2_edges", 64'(e), 64'd5);
    check("b2b2_busy_cycles", 64'(bn), 64'd4);
    check("b2b2_overlap", 64'(ov), 64'd0);
    check("b2b2_y_held_between", 64'(ys), 64'd1);
    check("b2b2_y", 64'(if0.y), 64'h1);
    check("b2b2_zero", 64'(if0.zero), 64'h0);
    @(negedge clk);

    // Reset mid-RUN after two slices
    if0.oprn = 3'b000;
    if0.a = 32'hFFFF_FFFF;
    if0.b = 32'hFFFF_FFFF;
    if0.start = 1'b1;
    @(negedge clk);
    if0.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("midrst_y", 64'(if0.y), 64'h0);
    check("midrst_zero", 64'(if0.zero), 64'h1);
    check("midrst_busy", 64'(if0.busy), 64'h0);
    check("midrst_done", 64'(if0.done), 64'h0);
    rst = 1'b0;
    dcnt = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (if0.done) dcnt++;
    end
    check("midrst_no_done", 64'(dcnt), 64'd0);
    check("midrst_y_after", 64'(if0.y), 64'h0);

    // WIDTH=16, SLICE=16 NAND
    if16.oprn = 3'b110;
    if16.a = 16'hFFFF;
    if16.b = 16'h00FF;
    if16.start = 1'b1;
    e = 0;
    do begin
      @(negedge clk);
      e++;
      if16.start = 1'b0;
    end while (!if16.done && e < 20);
    check("w16_edges", 64'(e), 64'd2);
    check("w16_y", 64'(if16.y), 64'hFF00);
    check("w16_zero", 64'(if16.zero), 64'h0);
    @(negedge clk);

    // WIDTH=64, SLICE=4 against the reference model
    for (int i = 0; i < 4; i++) begin
      a64 = (i == 0) ? 64'h0123_4567_89AB_CDEF : {32'($urandom), 32'($urandom)};
      b64 = (i == 0) ? 64'hFFFF_0000_F0F0_0F0F : {32'($urandom), 32'($urandom)};
      run64(3'((i * 3 + 2) % 8), a64, b64, e);
      check($sformatf("w64_edges_%0d", i), 64'(e), 64'd17);
      check($sformatf("w64_y_%0d", i), if64.y, ref64(3'((i * 3 + 2) % 8), a64, b64));
      @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
